bnn_image_loader: RTL and testbench

Front-end writer for the convolution stage. It accepts a byte stream over a valid/ready handshake and unpacks it into `IC` binary bit-planes of `IMG_IN_SIZE`×`IMG_IN_SIZE` pixels. It then raises `data_in_ready` and holds it, together with the planes, stable while the downstream conv layer runs. It sits between the host receive path (SPI/UART byte interface) and the first conv layer's `img_in`/`data_in_ready` inputs.

---
 rtl/bnn_pkg.sv | 13 +
 rtl/bit_plane_writer.sv | 44 ++++
 rtl/bnn_image_loader.sv | 125 ++++++++++++
 tb/tb_bnn_image_loader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared constants and loader state encoding for the BNN front end and conv layers.
package bnn_pkg;

    localparam int unsigned IMG_IN_SIZE = 30;
    localparam int unsigned IC          = 4;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_READY = 2'd2
    } loader_state_t;

endpackage : bnn_pkg

// File: rtl/bit_plane_writer.sv
// Decodes the eight bit positions of one incoming byte into plane index,
// bit offset and validity, plus a per-plane "any bit lands here" enable.
module bit_plane_writer #(
    parameter int unsigned IC          = 4,
    parameter int unsigned IMG_IN_SIZE = 30,
    parameter int unsigned PTR_W       = 12,
    parameter int unsigned PLANE_W     = 2,
    parameter int unsigned OFF_W       = 10
) (
    input  logic [PTR_W-1:0]   i_ptr,
    input  logic               i_wr_en,
    output logic [7:0]         o_bit_valid_c,
    output logic [PLANE_W-1:0] o_plane_idx_c [0:7],
    output logic [OFF_W-1:0]   o_bit_off_c   [0:7],
    output logic [IC-1:0]      o_plane_we_c
);

    localparam int unsigned N     = IMG_IN_SIZE * IMG_IN_SIZE;
    localparam int unsigned TOTAL = IC * N;

    // Global bit ptr+b -> (plane, offset); bits past the frame end are dropped.
    always_comb begin
        int unsigned w_g;
        w_g           = 0;
        o_bit_valid_c = '0;
        o_plane_we_c  = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            o_plane_idx_c[b] = '0;
            o_bit_off_c[b]   = '0;
        end
        for (int unsigned b = 0; b < 8; b++) begin
            w_g              = 32'(i_ptr) + b;
            o_bit_valid_c[b] = i_wr_en && (w_g < TOTAL);
            o_plane_idx_c[b] = PLANE_W'(w_g / N);
            o_bit_off_c[b]   = OFF_W'(w_g % N);
            for (int unsigned p = 0; p < IC; p++) begin
                if (o_bit_valid_c[b] && ((w_g / N) == p)) begin
                    o_plane_we_c[p] = 1'b1;
                end
            end
        end
    end

endmodule : bit_plane_writer

// File: rtl/bnn_image_loader.sv
// Byte-stream to bit-plane loader feeding the first conv layer; holds the
// assembled frame with data_in_ready high until the consumer releases it.
module bnn_image_loader #(
    parameter int unsigned IC          = bnn_pkg::IC,
    parameter int unsigned IMG_IN_SIZE = bnn_pkg::IMG_IN_SIZE
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         rx_data,
    input  logic                               rx_valid,
    output logic                               rx_ready,
    input  logic                               result_taken,
    output logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0] img_in [0:IC-1],
    output logic                               data_in_ready
);

    import bnn_pkg::*;

    localparam int unsigned N       = IMG_IN_SIZE * IMG_IN_SIZE;
    localparam int unsigned TOTAL   = IC * N;
    localparam int unsigned PTR_W   = $clog2(TOTAL + 8);
    localparam int unsigned PLANE_W = (IC > 1) ? $clog2(IC) : 1;
    localparam int unsigned OFF_W   = (N > 1) ? $clog2(N) : 1;

    loader_state_t      r_state;
    loader_state_t      w_state_next;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_next;
    logic               r_rx_ready;
    logic               r_data_in_ready;
    logic [N-1:0]       r_img [0:IC-1];

    logic               w_accept;
    logic               w_last;
    logic [7:0]         w_bit_valid_c;
    logic [PLANE_W-1:0] w_plane_idx_c [0:7];
    logic [OFF_W-1:0]   w_bit_off_c   [0:7];
    logic [IC-1:0]      w_plane_we_c;

    assign w_accept      = rx_valid && r_rx_ready;
    assign w_last        = (32'(r_ptr) + 32'd8) >= TOTAL;
    assign rx_ready      = r_rx_ready;
    assign data_in_ready = r_data_in_ready;
    assign img_in        = r_img;

    bit_plane_writer #(
        .IC          (IC),
        .IMG_IN_SIZE (IMG_IN_SIZE),
        .PTR_W       (PTR_W),
        .PLANE_W     (PLANE_W),
        .OFF_W       (OFF_W)
    ) u_writer (
        .i_ptr         (r_ptr),
        .i_wr_en       (w_accept),
        .o_bit_valid_c (w_bit_valid_c),
        .o_plane_idx_c (w_plane_idx_c),
        .o_bit_off_c   (w_bit_off_c),
        .o_plane_we_c  (w_plane_we_c)
    );

    // Next-state and pointer update; READY waits for the consumer release.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            LD_IDLE: begin
                if (w_accept) begin
                    w_ptr_next   = PTR_W'(8);
                    w_state_next = w_last ? LD_READY : LD_LOAD;
                end
            end
            LD_LOAD: begin
                if (w_accept) begin
                    w_ptr_next   = r_ptr + PTR_W'(8);
                    w_state_next = w_last ? LD_READY : LD_LOAD;
                end
            end
            LD_READY: begin
                if (result_taken) begin
                    w_state_next = LD_IDLE;
                    w_ptr_next   = '0;
                end
            end
            default: begin
                w_state_next = LD_IDLE;
                w_ptr_next   = '0;
            end
        endcase
    end

    // State, pointer and handshake flags; flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= LD_IDLE;
            r_ptr           <= '0;
            r_rx_ready      <= 1'b0;
            r_data_in_ready <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_ptr           <= w_ptr_next;
            r_rx_ready      <= (w_state_next != LD_READY);
            r_data_in_ready <= (w_state_next == LD_READY);
        end
    end

    // Plane storage: scatter accepted byte bits; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned p = 0; p < IC; p++) begin
                r_img[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < IC; p++) begin
                if (w_plane_we_c[p]) begin
                    for (int unsigned b = 0; b < 8; b++) begin
                        if (w_bit_valid_c[b] && (w_plane_idx_c[b] == PLANE_W'(p))) begin
                            r_img[p][w_bit_off_c[b]] <= rx_data[b];
                        end
                    end
                end
            end
        end
    end

endmodule : bnn_image_loader

// File: tb/tb_bnn_image_loader.sv
// Directed bench for bnn_image_loader across four parameter sets.
module tb_bnn_image_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Config A: IC=1, 4x4 (16 bits)
    logic [7:0]  a_data = '0;
    logic        a_valid = 1'b0, a_rdy, a_taken = 1'b0, a_dir;
    logic [15:0] a_img [0:0];
    // Config B: IC=2, 2x2 (8 bits)
    logic [7:0]  b_data = '0;
    logic        b_valid = 1'b0, b_rdy, b_taken = 1'b0, b_dir;
    logic [3:0]  b_img [0:1];
    // Config C: IC=1, 3x3 (9 bits)
    logic [7:0]  c_data = '0;
    logic        c_valid = 1'b0, c_rdy, c_taken = 1'b0, c_dir;
    logic [8:0]  c_img [0:0];
    // Config D: defaults IC=4, 30x30
    logic [7:0]   d_data = '0;
    logic         d_valid = 1'b0, d_rdy, d_taken = 1'b0, d_dir;
    logic [899:0] d_img [0:3];

    bnn_image_loader #(.IC(1), .IMG_IN_SIZE(4)) u_a (
        .clk(clk), .rst(rst), .rx_data(a_data), .rx_valid(a_valid), .rx_ready(a_rdy),
        .result_taken(a_taken), .img_in(a_img), .data_in_ready(a_dir));
    bnn_image_loader #(.IC(2), .IMG_IN_SIZE(2)) u_b (
        .clk(clk), .rst(rst), .rx_data(b_data), .rx_valid(b_valid), .rx_ready(b_rdy),
        .result_taken(b_taken), .img_in(b_img), .data_in_ready(b_dir));
    bnn_image_loader #(.IC(1), .IMG_IN_SIZE(3)) u_c (
        .clk(clk), .rst(rst), .rx_data(c_data), .rx_valid(c_valid), .rx_ready(c_rdy),
        .result_taken(c_taken), .img_in(c_img), .data_in_ready(c_dir));
    bnn_image_loader u_d (
        .clk(clk), .rst(rst), .rx_data(d_data), .rx_valid(d_valid), .rx_ready(d_rdy),
        .result_taken(d_taken), .img_in(d_img), .data_in_ready(d_dir));

    logic [7:0]   frame  [450];
    logic [899:0] exp_pl [4];

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fresh random frame plus its reference unpacking (plane-major, LSB first).
    task automatic gen_frame();
        logic [7:0] byte_v;
        for (int i = 0; i < 450; i++) frame[i] = 8'($urandom);
        for (int k = 0; k < 3600; k++) begin
            byte_v = frame[k / 8];
            exp_pl[k / 900][k % 900] = byte_v[k % 8];
        end
    endtask

    task automatic send_frame(input int n_bytes);
        for (int i = 0; i < n_bytes; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                d_valid = 1'b0;
                tick();
            end
            d_data  = frame[i];
            d_valid = 1'b1;
            tick();
        end
        d_valid = 1'b0;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        check("rdy_in_rst", a_rdy, 1'b0);
        rst = 1'b0;
        tick();
        check("rst_rdy", a_rdy, 1'b1);
        check("rst_dir", a_dir, 1'b0);
        check("rst_img", a_img[0], 16'h0);
        check("rst_d_img", d_img[3], '0);

        // A: two bytes back-to-back
        a_valid = 1'b1; a_data = 8'hA5;
        tick();
        check("a_mid_dir", a_dir, 1'b0);
        check("a_mid_img", a_img[0], 16'h00A5);
        a_data = 8'h3C;
        tick();
        check("a_img", a_img[0], 16'h3CA5);
        check("a_dir", a_dir, 1'b1);
        check("a_rdy", a_rdy, 1'b0);
        // Hold 0x55 in READY: must not be taken
        a_data = 8'h55;
        for (int i = 0; i < 10; i++) tick();
        check("a_hold_img", a_img[0], 16'h3CA5);
        check("a_hold_dir", a_dir, 1'b1);
        a_taken = 1'b1;
        tick();
        a_taken = 1'b0;
        check("a_rel_dir", a_dir, 1'b0);
        check("a_rel_rdy", a_rdy, 1'b1);
        check("a_rel_img", a_img[0], 16'h3CA5);
        tick();
        check("a_new_img", a_img[0], 16'h3C55);
        check("a_new_dir", a_dir, 1'b0);
        a_data = 8'h12;
        tick();
        a_valid = 1'b0;
        check("a_new2_img", a_img[0], 16'h1255);
        check("a_new2_dir", a_dir, 1'b1);

        // B: plane straddle within one byte, IDLE -> READY directly
        b_valid = 1'b1; b_data = 8'hB4;
        tick();
        b_valid = 1'b0;
        check("b_img0", b_img[0], 4'h4);
        check("b_img1", b_img[1], 4'hB);
        check("b_dir", b_dir, 1'b1);
        check("b_rdy", b_rdy, 1'b0);
        b_taken = 1'b1;
        tick();
        b_taken = 1'b0;
        check("b_rel_dir", b_dir, 1'b0);

        // C: tail bits beyond TOTAL dropped
        c_valid = 1'b1; c_data = 8'hFF;
        tick();
        check("c_mid_dir", c_dir, 1'b0);
        c_data = 8'hFE;
        tick();
        c_valid = 1'b0;
        check("c_img", c_img[0], 9'h0FF);
        check("c_dir", c_dir, 1'b1);

        // D: full default frame with gaps
        gen_frame();
        send_frame(450);
        check("d_dir", d_dir, 1'b1);
        check("d_rdy", d_rdy, 1'b0);
        for (int p = 0; p < 4; p++) check($sformatf("d_pl%0d", p), d_img[p], exp_pl[p]);
        for (int i = 0; i < 5; i++) tick();
        check("d_dir_held", d_dir, 1'b1);
        d_taken = 1'b1;
        tick();
        d_taken = 1'b0;
        check("d_rel_dir", d_dir, 1'b0);

        // D: reset mid-frame, then a clean frame
        gen_frame();
        send_frame(100);
        rst = 1'b1;
        tick();
        check("d_rst_dir", d_dir, 1'b0);
        check("d_rst_rdy", d_rdy, 1'b0);
        rst = 1'b0;
        tick();
        check("d_post_rdy", d_rdy, 1'b1);
        check("d_post_dir", d_dir, 1'b0);
        for (int p = 0; p < 4; p++) check($sformatf("d_zero%0d", p), d_img[p], '0);
        gen_frame();
        send_frame(450);
        check("d2_dir", d_dir, 1'b1);
        for (int p = 0; p < 4; p++) check($sformatf("d2_pl%0d", p), d_img[p], exp_pl[p]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bnn_image_loader
